// File: rtl/key_sw_port.sv
// Switch/pushbutton input port: synchronizes pins, debounces keys, captures presses and raises IRQ.
// Define KEY_DEBOUNCE_EN to include the per-key debounce counters; otherwise keys are used as synchronized.
module key_sw_port #(
    parameter int unsigned DW        = 16,
    parameter int unsigned NSW       = 10,
    parameter int unsigned NKEY      = 4,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [NSW-1:0]  SW,
    input  logic [NKEY-1:0] KEY,
    input  logic [1:0]      Addr,
    input  logic            Sel,
    input  logic            Wr,
    input  logic [NKEY-1:0] WrData,
    output logic [DW-1:0]   RdData,
    output logic            IRQ
);

    logic [NSW-1:0]  r_sw_m, r_sw_s;
    logic [NKEY-1:0] r_key_m, r_key_s;
    logic [NKEY-1:0] r_cap, r_mask;
    logic [NKEY-1:0] w_db, w_db_next, w_rise, w_clr;
    logic [DW-1:0]   w_rd_data;
    logic            w_rd_en, w_wr_en;

    // Two-flop synchronizers; keys reset to the released (high) level
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_sw_m  <= '0;
            r_sw_s  <= '0;
            r_key_m <= '1;
            r_key_s <= '1;
        end else begin
            r_sw_m  <= SW;
            r_sw_s  <= r_sw_m;
            r_key_m <= KEY;
            r_key_s <= r_key_m;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0]   r_cnt [NKEY];
    logic [NKEY-1:0] r_db;
    logic [NKEY-1:0] w_key_lvl;
    logic [NKEY-1:0] w_cnt_done;

    assign w_key_lvl = ~r_key_s;
    assign w_db      = r_db;

    // A key's new level is accepted once it has differed for DB_CYCLES consecutive cycles
    always_comb begin
        w_cnt_done = '0;
        w_db_next  = r_db;
        for (int i = 0; i < int'(NKEY); i++) begin
            w_cnt_done[i] = (w_key_lvl[i] != r_db[i]) && (r_cnt[i] == CW'(DB_CYCLES - 1));
            if (w_cnt_done[i]) w_db_next[i] = w_key_lvl[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_db <= '0;
            for (int i = 0; i < int'(NKEY); i++) r_cnt[i] <= '0;
        end else begin
            r_db <= w_db_next;
            for (int i = 0; i < int'(NKEY); i++) begin
                if (w_key_lvl[i] == r_db[i] || w_cnt_done[i]) r_cnt[i] <= '0;
                else r_cnt[i] <= r_cnt[i] + CW'(1);
            end
        end
    end
`else
    logic w_unused_db;

    assign w_unused_db = ^32'(DB_CYCLES);
    assign w_db        = ~r_key_s;
    assign w_db_next   = ~r_key_m;
`endif

    assign w_rd_en = Sel && !Wr;
    assign w_wr_en = Sel && Wr;
    assign w_rise  = w_db_next & ~w_db;
    assign w_clr   = (w_wr_en && Addr == 2'd2) ? WrData : '0;

    always_comb begin
        w_rd_data = '0;
        case (Addr)
            2'd0:    w_rd_data = DW'(r_sw_s);
            2'd1:    w_rd_data = DW'(w_db);
            2'd2:    w_rd_data = DW'(r_cap);
            default: w_rd_data = DW'(r_mask);
        endcase
    end

    // Bus registers; a capture set in the same cycle as its clear wins
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_cap  <= '0;
            r_mask <= '0;
            RdData <= '0;
            IRQ    <= 1'b0;
        end else begin
            r_cap  <= (r_cap & ~w_clr) | w_rise;
            if (w_wr_en && Addr == 2'd3) r_mask <= WrData;
            IRQ    <= |(r_cap & r_mask);
            RdData <= w_rd_en ? w_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_key_sw_port.sv
// Directed bench for key_sw_port with a cycle model checked every cycle plus literal checkpoints.
module tb_key_sw_port;
    localparam int unsigned DW = 16, NSW = 10, NKEY = 4, DB = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic            Clock = 1'b0;
    logic            Resetn;
    logic [NSW-1:0]  SW;
    logic [NKEY-1:0] KEY;
    logic [1:0]      Addr;
    logic            Sel, Wr;
    logic [NKEY-1:0] WrData;
    logic [DW-1:0]   RdData;
    logic            IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    key_sw_port #(.DW(DW), .NSW(NSW), .NKEY(NKEY), .DB_CYCLES(DB)) dut (
        .Clock(Clock), .Resetn(Resetn), .SW(SW), .KEY(KEY), .Addr(Addr),
        .Sel(Sel), .Wr(Wr), .WrData(WrData), .RdData(RdData), .IRQ(IRQ)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: pressed-level history, per-key disagreement run lengths
    logic [NSW-1:0]  m_sw  [2];
    logic [NKEY-1:0] m_kp  [2];
    int              m_run [NKEY];
    logic [NKEY-1:0] m_db, m_cap, m_mask;
    logic [DW-1:0]   m_rd;
    logic            m_irq;
    logic            m_valid = 1'b0;

    always @(posedge Clock) begin
        logic [NKEY-1:0] ndb, clr;
        if (!Resetn) begin
            m_sw[0] <= '0; m_sw[1] <= '0;
            m_kp[0] <= '0; m_kp[1] <= '0;
            for (int k = 0; k < int'(NKEY); k++) m_run[k] <= 0;
            m_db <= '0; m_cap <= '0; m_mask <= '0; m_rd <= '0; m_irq <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            ndb = m_db;
`ifdef KEY_DEBOUNCE_EN
            for (int k = 0; k < int'(NKEY); k++) begin
                if (m_kp[1][k] == m_db[k]) m_run[k] <= 0;
                else if (m_run[k] + 1 == int'(DB)) begin
                    ndb[k] = m_kp[1][k];
                    m_run[k] <= 0;
                end else m_run[k] <= m_run[k] + 1;
            end
`else
            ndb = m_kp[0];
`endif
            clr = (Sel && Wr && Addr == 2'd2) ? WrData : '0;
            m_cap <= (m_cap & ~clr) | (ndb & ~m_db);
            m_db  <= ndb;
            m_irq <= |(m_cap & m_mask);
            if (Sel && Wr && Addr == 2'd3) m_mask <= WrData;
            if (Sel && !Wr)
                case (Addr)
                    2'd0: m_rd <= DW'(m_sw[1]);
                    2'd1: m_rd <= DW'(m_db);
                    2'd2: m_rd <= DW'(m_cap);
                    default: m_rd <= DW'(m_mask);
                endcase
            else m_rd <= '0;
            m_sw[0] <= SW;  m_sw[1] <= m_sw[0];
            m_kp[0] <= ~KEY; m_kp[1] <= m_kp[0];
        end
    end

    always @(negedge Clock) begin
        if (m_valid) begin
            chk("model_rddata", 32'(RdData), 32'(m_rd));
            chk("model_irq", 32'(IRQ), 32'(m_irq));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic rd(input logic [1:0] a, output logic [DW-1:0] d);
        Sel = 1'b1; Wr = 1'b0; Addr = a;
        @(negedge Clock);
        Sel = 1'b0;
        d = RdData;
    endtask

    task automatic wr(input logic [1:0] a, input logic [NKEY-1:0] d);
        Sel = 1'b1; Wr = 1'b1; Addr = a; WrData = d;
        @(negedge Clock);
        Sel = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        Resetn = 1'b0; KEY = '0; SW = 10'h3FF; Addr = '0; Sel = 1'b0; Wr = 1'b0; WrData = '0;
        tick(2);
        chk("reset_rddata", 32'(RdData), 32'h0);
        chk("reset_irq", 32'(IRQ), 32'h0);
        Resetn = 1'b1;
        rd(2'd2, d); chk("reset_cap", 32'(d), 32'h0);
        KEY = '1;
        tick(12);
        wr(2'd2, 4'hF);

        // Switch level read and ignored write to Addr 0
        SW = 10'h2A5;
        tick(3);
        rd(2'd0, d); chk("sw_read", 32'(d), 32'h02A5);
        wr(2'd0, 4'hF);
        rd(2'd0, d); chk("sw_after_wr0", 32'(d), 32'h02A5);
        rd(2'd1, d); chk("keylvl_idle", 32'(d), 32'h0);

`ifdef KEY_DEBOUNCE_EN
        KEY = 4'b1101; tick(3); KEY = 4'hF;
        tick(10);
        rd(2'd1, d); chk("glitch_lvl", 32'(d), 32'h0);
        rd(2'd2, d); chk("glitch_cap", 32'(d), 32'h0);
`else
        KEY = 4'b1011;
        Sel = 1'b1; Wr = 1'b0; Addr = 2'd2;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clock);
            if (i == 1) KEY = 4'hF;
            if (i == LAT) chk("short_press_early", 32'(RdData), 32'h0);
            if (i == LAT + 1) chk("short_press_cap", 32'(RdData), 32'h0004);
        end
        Sel = 1'b0;
        tick(4);
        wr(2'd2, 4'hF);
        tick(2);
`endif

        // KEY[1] held: capture appears exactly LAT edges after the pin change
        KEY = 4'b1101;
        Sel = 1'b1; Wr = 1'b0; Addr = 2'd2;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            if (i == LAT) chk("press_cap_early", 32'(RdData), 32'h0);
            if (i == LAT + 1) chk("press_cap", 32'(RdData), 32'h0002);
        end
        Sel = 1'b0;
        KEY = 4'hF;
        rd(2'd1, d); chk("press_lvl", 32'(d), 32'h0002);
        tick(12);
        rd(2'd2, d); chk("release_no_set", 32'(d), 32'h0002);

        // Build capture 0110, then mask/IRQ/clear
        KEY = 4'b1011; tick(10); KEY = 4'hF; tick(12);
        rd(2'd2, d); chk("cap_0110", 32'(d), 32'h0006);
        wr(2'd3, 4'b0100);
        tick(1);
        chk("irq_set", 32'(IRQ), 32'h1);
        wr(2'd2, 4'b0100);
        chk("irq_clear_edge", 32'(IRQ), 32'h1);
        rd(2'd2, d); chk("cap_after_clr", 32'(d), 32'h0002);
        chk("irq_cleared", 32'(IRQ), 32'h0);
        wr(2'd3, 4'b0000);
        rd(2'd3, d); chk("mask_rb", 32'(d), 32'h0);

        // Clear bit 0 on the very edge its debounced level rises
        KEY = 4'b1110;
        tick(LAT - 1);
        wr(2'd2, 4'b0001);
        tick(4);
        rd(2'd2, d); chk("set_beats_clear", 32'(d), 32'h0003);
        KEY = 4'hF; tick(12);

        // Reset mid-debounce with a concurrent mask write
        KEY = 4'b0111; tick(3);
        Resetn = 1'b0; Sel = 1'b1; Wr = 1'b1; Addr = 2'd3; WrData = 4'hF;
        tick(1);
        Resetn = 1'b1; Sel = 1'b0; Wr = 1'b0;
        rd(2'd3, d); chk("reset_beats_wr", 32'(d), 32'h0);
        rd(2'd2, d); chk("reset_cap_cleared", 32'(d), 32'h0);
        tick(10);
        rd(2'd2, d); chk("press_after_reset", 32'(d), 32'h0008);
        KEY = 4'hF; tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
